layer_mixer: RTL

Parametrised, pipelined pixel compositor for the HDMI video path. It takes N overlay layers (buttons, grid, text strings), each supplying an active flag and an RGB colour for the current pixel. It resolves them by fixed priority or by two-layer 50 % blend, applies per-layer visibility and frame-counted blink, and drives the RGB bus into `hdmi`. It also reports per-frame layer overlap, where the old one-hot case mux silently produced black.

---
 rtl/layer_mixer.sv | 84 ++++++++
 1 files changed

// File: rtl/layer_mixer.sv
// layer_mixer: two-stage priority/blend pixel compositor with frame-counted blink
// and a per-frame flag for pixels where two or more visible layers overlap.
module layer_mixer #(
  parameter int N_LAYERS     = 5,
  parameter int CW           = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fs,
  input  logic                       de_in,
  input  logic [N_LAYERS-1:0]        layer_en,
  input  logic [N_LAYERS*3*CW-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]        layer_mask,
  input  logic [N_LAYERS-1:0]        blink_mask,
  input  logic                       blend_mode,
  input  logic [3*CW-1:0]            bg_rgb,
  output logic [3*CW-1:0]            rgb_out,
  output logic                       de_out,
  output logic                       collision,
  output logic                       blink_phase
);
  localparam int W  = 3*CW;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [N_LAYERS-1:0]   r_act1;
  logic [N_LAYERS*W-1:0] r_rgb1;
  logic [W-1:0]          r_bg1;
  logic                  r_blend1, r_de1, r_ovl;
  logic [BW-1:0]         r_cnt;
  logic [W-1:0]          w_pc, w_qc, w_blend;
  logic                  w_two, w_ovl_now;
  // clearing the lowest set bit leaves something only when two or more are set
  assign w_two     = |(r_act1 & (r_act1 - N_LAYERS'(1)));
  assign w_ovl_now = r_de1 & w_two;
  always_comb begin
    w_pc = '0;
    w_qc = '0;
    for (int i = N_LAYERS-1; i >= 0; i--)
      if (r_act1[i]) begin
        w_qc = w_pc;
        w_pc = r_rgb1[i*W +: W];
      end
  end
  genvar c;
  for (c = 0; c < 3; c++) begin : g_blend
    logic [CW:0] w_sum;
    assign w_sum = {1'b0, w_pc[c*CW +: CW]} + {1'b0, w_qc[c*CW +: CW]};
    assign w_blend[c*CW +: CW] = w_sum[CW:1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act1   <= '0;
      r_rgb1   <= '0;
      r_bg1    <= '0;
      r_blend1 <= 1'b0;
      r_de1    <= 1'b0;
      rgb_out  <= '0;
      de_out   <= 1'b0;
    end else begin
      r_act1   <= layer_en & layer_mask & ~(blink_mask & {N_LAYERS{blink_phase}});
      r_rgb1   <= layer_rgb;
      r_bg1    <= bg_rgb;
      r_blend1 <= blend_mode;
      r_de1    <= de_in;
      rgb_out  <= !r_de1 ? '0 : ~|r_act1 ? r_bg1 : (r_blend1 && w_two) ? w_blend : w_pc;
      de_out   <= r_de1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      blink_phase <= 1'b0;
      r_ovl       <= 1'b0;
      collision   <= 1'b0;
    end else if (fs) begin
      r_cnt       <= (r_cnt == BW'(BLINK_FRAMES-1)) ? '0 : r_cnt + BW'(1);
      blink_phase <= (r_cnt == BW'(BLINK_FRAMES-1)) ? ~blink_phase : blink_phase;
      collision   <= r_ovl | w_ovl_now;
      r_ovl       <= 1'b0;
    end else if (w_ovl_now) begin
      r_ovl       <= 1'b1;
    end
  end
endmodule
